// File: rtl/lp_csr_gen_if.sv
// Device-side bus of lp_csr_gen: UBA write/strobe inputs, device status,
// and the command/control/readback outputs toward the device core.
interface lp_csr_gen_if #(
  parameter int NERR  = 6,
  parameter int NEDGE = 2,
  parameter int MODEW = 2
);
  logic             devRESET;
  logic             devLOBYTE;
  logic             devHIBYTE;
  logic [35:0]      devDATAI;
  logic             csrWRITE;
  logic             errWRITE;
  logic [NERR-1:0]  lvlERR;
  logic [NEDGE-1:0] edgeSTAT;
  logic             stsDONE;
  logic             stsGO;
  logic             intACK;
  logic             cmdGO;
  logic             cmdINIT;
  logic             cmdECLR;
  logic             ctlIE;
  logic [MODEW-1:0] ctlMODE;
  logic             ctlPAR;
  logic             intREQ;
  logic [15:0]      regCSR;
  logic [15:0]      regERR;

  modport master (
    output devRESET, devLOBYTE, devHIBYTE, devDATAI, csrWRITE, errWRITE,
    output lvlERR, edgeSTAT, stsDONE, stsGO, intACK,
    input  cmdGO, cmdINIT, cmdECLR, ctlIE, ctlMODE, ctlPAR, intREQ, regCSR, regERR
  );

  modport slave (
    input  devRESET, devLOBYTE, devHIBYTE, devDATAI, csrWRITE, errWRITE,
    input  lvlERR, edgeSTAT, stsDONE, stsGO, intACK,
    output cmdGO, cmdINIT, cmdECLR, ctlIE, ctlMODE, ctlPAR, intREQ, regCSR, regERR
  );
endinterface

// File: rtl/lp_csr_gen.sv
// Generic Unibus device CSR: control bits, command pulses, sticky W1C error
// register with first-error capture, and a single-level interrupt request FSM.
module lp_csr_gen #(
  parameter int NERR  = 6,
  parameter int NEDGE = 2,
  parameter int MODEW = 2
) (
  input logic         clk,
  input logic         rst,
  lp_csr_gen_if.slave bus
);
  localparam int NTOT = NERR + NEDGE;

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} irq_state_e;

  function automatic logic [3:0] lowest_idx(input logic [NTOT-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NTOT - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [15:0]      data_s;
  logic             cmd_init_s, cmd_eclr_s, cmd_go_s, csr_lo_wr_s;
  logic             ie_q, ie_d, par_q, par_d;
  logic [MODEW-1:0] mode_q, mode_d;
  logic [1:0]       mode_ext_s;
  logic [NEDGE-1:0] hist_q, hist_d;
  logic [NTOT-1:0]  src_s, e_q, e_d;
  logic [15:0]      clr_s, reg_err_s;
  logic [3:0]       first_q, first_d;
  logic             firstv_q, firstv_d;
  logic             done_prev_q, done_prev_d, err_prev_q, err_prev_d;
  logic             err_s, done_rose_s, err_rose_s, int_req_s;
  irq_state_e       state_q, state_d;
  logic             unused_s;

  assign data_s   = bus.devDATAI[15:0];
  assign unused_s = ^bus.devDATAI[35:16];

  // Command pulses; INIT implies error clear.
  always_comb begin
    csr_lo_wr_s = bus.csrWRITE & bus.devLOBYTE;
    cmd_init_s  = bus.devRESET | (bus.csrWRITE & bus.devHIBYTE & data_s[8]);
    cmd_eclr_s  = cmd_init_s | (csr_lo_wr_s & data_s[2]);
    cmd_go_s    = csr_lo_wr_s & data_s[0];
  end

  // Control bits: INIT wins over a simultaneous low-byte write.
  always_comb begin
    ie_d   = ie_q;
    mode_d = mode_q;
    par_d  = par_q;
    if (cmd_init_s) begin
      ie_d   = 1'b0;
      mode_d = '0;
      par_d  = 1'b0;
    end else if (csr_lo_wr_s) begin
      ie_d   = data_s[6];
      mode_d = data_s[4 +: MODEW];
      par_d  = data_s[3];
    end else begin
      ie_d   = ie_q;
    end
  end

  // Sticky error bits: an active source beats any clear in the same cycle.
  always_comb begin
    hist_d = bus.edgeSTAT;
    src_s  = {~bus.edgeSTAT & hist_q, bus.lvlERR};
    clr_s  = {{8{bus.devHIBYTE}}, {8{bus.devLOBYTE}}} & data_s & {16{bus.errWRITE}};
    if (cmd_eclr_s) begin
      e_d = src_s;
    end else begin
      e_d = src_s | (e_q & ~clr_s[NTOT-1:0]);
    end
    err_s = |e_q;
  end

  // First-error capture, armed only while the error register is empty.
  always_comb begin
    first_d  = first_q;
    firstv_d = firstv_q;
    if ((e_q == '0) && (src_s != '0)) begin
      first_d  = lowest_idx(src_s);
      firstv_d = 1'b1;
    end else if (e_d == '0) begin
      firstv_d = 1'b0;
    end else begin
      firstv_d = firstv_q;
    end
  end

  // Interrupt FSM; ie_d already folds in INIT and same-cycle IE writes.
  always_comb begin
    done_prev_d = bus.stsDONE;
    err_prev_d  = err_s;
    done_rose_s = bus.stsDONE & ~done_prev_q;
    err_rose_s  = err_s & ~err_prev_q;
    state_d     = state_q;
    case (state_q)
      IDLE: begin
        if (ie_d & (done_rose_s | err_rose_s | (~ie_q & (bus.stsDONE | err_s)))) begin
          state_d = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (bus.intACK | ~ie_d) begin
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q        <= 1'b0;
      mode_q      <= '0;
      par_q       <= 1'b0;
      hist_q      <= '0;
      e_q         <= '0;
      first_q     <= 4'd0;
      firstv_q    <= 1'b0;
      done_prev_q <= 1'b0;
      err_prev_q  <= 1'b0;
      state_q     <= IDLE;
    end else begin
      ie_q        <= ie_d;
      mode_q      <= mode_d;
      par_q       <= par_d;
      hist_q      <= hist_d;
      e_q         <= e_d;
      first_q     <= first_d;
      firstv_q    <= firstv_d;
      done_prev_q <= done_prev_d;
      err_prev_q  <= err_prev_d;
      state_q     <= state_d;
    end
  end

  // Readback formatting.
  always_comb begin
    int_req_s             = (state_q == PEND);
    mode_ext_s            = 2'b00;
    mode_ext_s[MODEW-1:0] = mode_q;
    reg_err_s             = 16'h0000;
    reg_err_s[NTOT-1:0]   = e_q;
  end

  assign bus.cmdGO   = cmd_go_s;
  assign bus.cmdINIT = cmd_init_s;
  assign bus.cmdECLR = cmd_eclr_s;
  assign bus.ctlIE   = ie_q;
  assign bus.ctlMODE = mode_q;
  assign bus.ctlPAR  = par_q;
  assign bus.intREQ  = int_req_s;
  assign bus.regERR  = reg_err_s;
  assign bus.regCSR  = {err_s, firstv_q, first_q, 1'b0, cmd_init_s, bus.stsDONE,
                        ie_q, mode_ext_s, par_q, cmd_eclr_s, int_req_s, bus.stsGO};
endmodule

// File: tb/tb_lp_csr_gen.sv
// Directed scenarios plus randomized traffic for lp_csr_gen, all compared
// every cycle against a behavioural model of the register's rules.
module tb_lp_csr_gen;
  localparam int NERR  = 6;
  localparam int NEDGE = 2;
  localparam int MODEW = 2;
  localparam int NTOT  = NERR + NEDGE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lp_csr_gen_if #(.NERR(NERR), .NEDGE(NEDGE), .MODEW(MODEW)) bus();
  lp_csr_gen #(.NERR(NERR), .NEDGE(NEDGE), .MODEW(MODEW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit m_ie, m_par, m_firstv, m_pend, m_done_prev, m_err_prev;
  int m_mode, m_first;
  bit m_e[NTOT];
  bit m_hist[NEDGE];

  function automatic logic [15:0] model_errw();
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < NTOT; i++) w[i] = m_e[i];
    return w;
  endfunction

  task automatic model_reset();
    m_ie = 0; m_par = 0; m_firstv = 0; m_pend = 0; m_done_prev = 0; m_err_prev = 0;
    m_mode = 0; m_first = 0;
    for (int i = 0; i < NTOT; i++) m_e[i] = 0;
    for (int j = 0; j < NEDGE; j++) m_hist[j] = 0;
  endtask

  task automatic model_cycle();
    logic [15:0] d;
    bit init, eclr, go, lo_wr, err, any_src, any_new, lane, n_ie, n_par, done_rose, err_rose;
    int n_mode, csr;
    bit src[NTOT];
    bit new_e[NTOT];
    d     = bus.devDATAI[15:0];
    lo_wr = bus.csrWRITE && bus.devLOBYTE;
    init  = bus.devRESET || (bus.csrWRITE && bus.devHIBYTE && d[8]);
    eclr  = init || (lo_wr && d[2]);
    go    = lo_wr && d[0];
    err   = 0;
    for (int i = 0; i < NTOT; i++) err = err || m_e[i];
    csr = (int'(err) << 15) + (int'(m_firstv) << 14) + (m_first << 10) + (int'(init) << 8)
        + (int'(bus.stsDONE) << 7) + (int'(m_ie) << 6) + (m_mode << 4) + (int'(m_par) << 3)
        + (int'(eclr) << 2) + (int'(m_pend) << 1) + int'(bus.stsGO);
    chk("regCSR", bus.regCSR, 16'(csr));
    chk("regERR", bus.regERR, model_errw());
    chk("intREQ", {15'd0, bus.intREQ}, {15'd0, m_pend});
    chk("cmdGO", {15'd0, bus.cmdGO}, {15'd0, go});
    chk("cmdINIT", {15'd0, bus.cmdINIT}, {15'd0, init});
    chk("cmdECLR", {15'd0, bus.cmdECLR}, {15'd0, eclr});
    chk("ctl", {12'd0, bus.ctlIE, bus.ctlMODE, bus.ctlPAR}, 16'((int'(m_ie) << 3) + (m_mode << 1) + int'(m_par)));

    n_ie = m_ie; n_mode = m_mode; n_par = m_par;
    if (init) begin
      n_ie = 0; n_mode = 0; n_par = 0;
    end else if (lo_wr) begin
      n_ie = d[6]; n_mode = int'(d[5:4]); n_par = d[3];
    end
    for (int i = 0; i < NERR; i++) src[i] = bus.lvlERR[i];
    for (int j = 0; j < NEDGE; j++) src[NERR+j] = m_hist[j] && !bus.edgeSTAT[j];
    any_src = 0; any_new = 0;
    for (int i = 0; i < NTOT; i++) begin
      lane     = (i < 8) ? bus.devLOBYTE : bus.devHIBYTE;
      new_e[i] = src[i] || (!eclr && m_e[i] && !(bus.errWRITE && lane && d[i]));
      any_src  = any_src || src[i];
      any_new  = any_new || new_e[i];
    end
    if (!err && any_src) begin
      m_firstv = 1;
      for (int i = NTOT - 1; i >= 0; i--) if (src[i]) m_first = i;
    end else if (!any_new) begin
      m_firstv = 0;
    end
    done_rose = bus.stsDONE && !m_done_prev;
    err_rose  = err && !m_err_prev;
    if (m_pend) m_pend = !(bus.intACK || !n_ie);
    else        m_pend = n_ie && (done_rose || err_rose || (!m_ie && (bus.stsDONE || err)));
    m_ie = n_ie; m_mode = n_mode; m_par = n_par;
    for (int i = 0; i < NTOT; i++) m_e[i] = new_e[i];
    for (int j = 0; j < NEDGE; j++) m_hist[j] = bus.edgeSTAT[j];
    m_done_prev = bus.stsDONE;
    m_err_prev  = err;
  endtask

  // Compare process: inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    if (rst) model_reset();
    else     model_cycle();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.devRESET = 0; bus.devLOBYTE = 0; bus.devHIBYTE = 0; bus.devDATAI = 36'd0;
    bus.csrWRITE = 0; bus.errWRITE = 0; bus.lvlERR = '0; bus.intACK = 0;
  endtask

  task automatic csr_lo(input logic [15:0] d);
    bus.csrWRITE = 1; bus.devLOBYTE = 1; bus.devDATAI = {20'd0, d};
  endtask

  task automatic err_w1c(input logic [15:0] d);
    bus.errWRITE = 1; bus.devLOBYTE = 1; bus.devHIBYTE = 1; bus.devDATAI = {20'd0, d};
  endtask

  initial begin
    idle();
    bus.edgeSTAT = '0; bus.stsDONE = 0; bus.stsGO = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_csr", bus.regCSR, 16'h0000);
    chk("rst_err", bus.regERR, 16'h0000);
    chk("rst_irq", {15'd0, bus.intREQ}, 16'h0000);
    tick();

    csr_lo(16'h0059);
    @(negedge clk); chk("go_pulse", {15'd0, bus.cmdGO}, 16'h0001);
    tick(); idle();
    @(negedge clk); chk("go_clear", {15'd0, bus.cmdGO}, 16'h0000);
    chk("ctl_bits", {12'd0, bus.regCSR[6:3]}, 16'h000B);
    tick();
    bus.csrWRITE = 1; bus.devDATAI = 36'h4;
    @(negedge clk); chk("nolane_eclr", {15'd0, bus.cmdECLR}, 16'h0000);
    tick(); idle();
    @(negedge clk); chk("nolane_ctl", {12'd0, bus.regCSR[6:3]}, 16'h000B);
    tick();

    bus.lvlERR = 6'b001000; tick();
    bus.lvlERR = 6'b000010; tick(); idle();
    @(negedge clk);
    chk("err_a", bus.regERR, 16'h000A);
    chk("first_a", {11'd0, bus.regCSR[14:10]}, 16'h0013);
    tick();
    chk("model_err_a", model_errw(), 16'h000A);
    chk("model_first_a", 16'(m_first), 16'h0003);
    err_w1c(16'h0008); tick(); idle();
    @(negedge clk);
    chk("err_b", bus.regERR, 16'h0002);
    chk("first_b", {11'd0, bus.regCSR[14:10]}, 16'h0013);
    tick();
    err_w1c(16'h0002); tick(); idle();
    @(negedge clk);
    chk("err_c", bus.regERR, 16'h0000);
    chk("firstv_c", {15'd0, bus.regCSR[14]}, 16'h0000);
    tick();

    bus.edgeSTAT = 2'b01; tick();
    bus.edgeSTAT = 2'b00; tick();
    @(negedge clk); chk("edge_fall", bus.regERR, 16'h0040);
    tick();
    err_w1c(16'h0040); tick(); idle();
    bus.edgeSTAT = 2'b01; tick(); tick();
    @(negedge clk); chk("edge_rise", bus.regERR, 16'h0000);
    tick();
    bus.lvlERR = 6'b000100; err_w1c(16'h0004); tick(); idle();
    @(negedge clk); chk("set_beats_clr", bus.regERR, 16'h0004);
    tick();
    err_w1c(16'h0004); tick(); idle();
    @(negedge clk); chk("err_clr2", bus.regERR, 16'h0000);
    tick();
    bus.intACK = 1; tick(); idle();
    @(negedge clk); chk("irq_acked", {15'd0, bus.intREQ}, 16'h0000);
    tick();

    bus.stsDONE = 1;
    @(negedge clk); chk("done_same", {15'd0, bus.intREQ}, 16'h0000);
    tick();
    @(negedge clk); chk("done_irq", {15'd0, bus.intREQ}, 16'h0001);
    tick();
    bus.intACK = 1; tick(); idle();
    @(negedge clk); chk("done_ack", {15'd0, bus.intREQ}, 16'h0000);
    tick();
    bus.stsDONE = 0; csr_lo(16'h0000); tick(); idle(); tick();
    bus.stsDONE = 1; tick(); tick();
    @(negedge clk); chk("done_ie0", {15'd0, bus.intREQ}, 16'h0000);
    tick();
    csr_lo(16'h0040); tick(); idle();
    @(negedge clk); chk("dec_ie", {15'd0, bus.intREQ}, 16'h0001);
    tick();
    bus.lvlERR = 6'b000001; tick(); idle();
    @(negedge clk); chk("err_sum", {15'd0, bus.regCSR[15]}, 16'h0001);
    tick();
    bus.csrWRITE = 1; bus.devHIBYTE = 1; bus.devDATAI = 36'h100;
    @(negedge clk);
    chk("init_pulse", {15'd0, bus.cmdINIT}, 16'h0001);
    chk("eclr_pulse", {15'd0, bus.cmdECLR}, 16'h0001);
    tick(); idle();
    @(negedge clk);
    chk("init_ctl", {12'd0, bus.regCSR[6:3]}, 16'h0000);
    chk("init_err", bus.regERR, 16'h0000);
    chk("init_irq", {15'd0, bus.intREQ}, 16'h0000);
    tick();

    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        idle();
        rst = 1;
        #1;
        chk("async_err", bus.regERR, 16'h0000);
        chk("async_irq", {15'd0, bus.intREQ}, 16'h0000);
        chk("async_ie", {15'd0, bus.ctlIE}, 16'h0000);
        tick(); tick();
        rst = 0;
      end
      bus.devRESET  = ($urandom_range(0, 63) == 0);
      bus.csrWRITE  = ($urandom_range(0, 5) == 0);
      bus.errWRITE  = ($urandom_range(0, 5) == 0);
      bus.devLOBYTE = 1'($urandom);
      bus.devHIBYTE = ($urandom_range(0, 3) == 0);
      bus.devDATAI  = {4'($urandom), 32'($urandom)};
      for (int b = 0; b < NERR; b++) bus.lvlERR[b] = ($urandom_range(0, 11) == 0);
      for (int b = 0; b < NEDGE; b++)
        if ($urandom_range(0, 5) == 0) bus.edgeSTAT[b] = ~bus.edgeSTAT[b];
      if ($urandom_range(0, 7) == 0) bus.stsDONE = ~bus.stsDONE;
      bus.stsGO  = 1'($urandom);
      bus.intACK = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lp_csr_gen.md
Name: lp_csr_gen

Overview:
- Parametrised successor to the LP20 CSRA block: a generic device control/status register for Unibus-attached peripherals.
- Provides a command/status register (CSR) with byte-lane writes, self-clearing INIT/ECLR/GO pulses, and IE/MODE/PAR control bits.
- Adds a per-source sticky error register (write-one-to-clear) with a configurable mix of level-triggered and falling-edge error sources.
- Adds first-error capture and an interrupt request/acknowledge state machine; sits between the UBA device interface and the device core.

Parameters:
NERR, 6, number of level-sensitive error sources (1..15)
NEDGE, 2, number of status inputs whose falling edge is an error (1..15); NERR+NEDGE <= 16
MODEW, 2, width of MODE field (1..2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
devRESET  in  1  device reset from UBA (acts as INIT)
devLOBYTE  in  1  low byte lane enable
devHIBYTE  in  1  high byte lane enable
devDATAI  in  36  device write data (bits 15:0 used)
csrWRITE  in  1  write strobe, CSR
errWRITE  in  1  write strobe, error register
lvlERR  in  NERR  level error sources
edgeSTAT  in  NEDGE  monitored status (error on 1->0)
stsDONE  in  1  device done
stsGO  in  1  device busy/go status
intACK  in  1  interrupt acknowledge, one-cycle pulse
cmdGO  out  1  GO pulse
cmdINIT  out  1  INIT pulse
cmdECLR  out  1  error-clear pulse
ctlIE  out  1  interrupt enable
ctlMODE  out  MODEW  mode
ctlPAR  out  1  parity enable
intREQ  out  1  interrupt request
regCSR  out  16  CSR readback
regERR  out  16  error register readback, zero-padded above NERR+NEDGE

Behaviour:
- Reset: all registers 0, so intREQ=0, ctlIE=0, ctlMODE=0, ctlPAR=0, regERR=0, FIRSTV=0, edge history=0.
- Combinational pulses:
  - cmdINIT = devRESET | (csrWRITE & devHIBYTE & D[8]).
  - cmdECLR = cmdINIT | (csrWRITE & devLOBYTE & D[2]).
  - cmdGO = csrWRITE & devLOBYTE & D[0].
- Control bits: IE=D[6], MODE=D[4 +: MODEW], PAR=D[3].
  - Loaded on csrWRITE & devLOBYTE.
  - Cleared by cmdINIT, which wins over a simultaneous write.
- Edge history: register per edgeSTAT bit, updated every cycle.
  - Edge error i = !edgeSTAT[i] & hist[i].
  - History resets to 0, so a source held low through reset release is not an error.
- Error register E[NERR+NEDGE-1:0]:
  - Bits 0..NERR-1 are lvlERR; bits NERR.. are the edge errors.
  - Each bit is set when its source is active.
  - Otherwise cleared by cmdECLR.
  - Otherwise cleared by errWRITE with a 1 in that bit position, only within an enabled byte lane (bits 7:0 need devLOBYTE, bits 15:8 need devHIBYTE).
  - Set beats clear in the same cycle. A persistently high level source cannot be cleared.
- ERR summary = |E (registered bits, one cycle after the source).
- First-error capture:
  - When E==0 and any source becomes active, latch FIRST = lowest active source index and set FIRSTV=1.
  - Both hold until E returns to all-zero, then FIRSTV clears in that same cycle.
  - Later errors never overwrite FIRST.
- regCSR layout:
  - [15] ERR, [14] FIRSTV, [13:10] FIRST, [9] 0, [8] cmdINIT, [7] stsDONE, [6] IE.
  - [5:4] MODE, zero-extended when MODEW=1; [3] PAR, [2] cmdECLR, [1] intREQ, [0] stsGO.
- Interrupt FSM, states IDLE and PEND; intREQ=1 only in PEND.
  - IDLE->PEND: IE=1 and (stsDONE rose, i.e. done history 0->1, or ERR rose 0->1).
  - Also IDLE->PEND when IE is written 0->1 while stsDONE=1 or ERR=1 (DEC convention).
  - PEND->IDLE: intACK, or IE=0, or cmdINIT.
  - A new event during PEND is absorbed, not queued.
  - intACK in IDLE is ignored.
  - Transitions take effect on the clock edge after the event; intREQ latency is 1 cycle from the stsDONE rise.
- Reset mid-operation: async rst clears everything immediately. devRESET is synchronous INIT and clears control bits, E and the FSM on the next edge; edge history is unaffected.

Test Plan:
- Reset, then read: regCSR=16'h0000 with stsDONE=stsGO=0; regERR=0; intREQ=0.
- CSR write low byte D=16'h0059 (IE=1, MODE=01, PAR=1, GO=1): cmdGO one-cycle pulse; regCSR[6:3]=4'b1011. Same write with devLOBYTE=0: nothing changes.
- NERR=6, NEDGE=2: pulse lvlERR[3] then lvlERR[1]. Result: regERR=16'h000A, FIRST=3, FIRSTV=1. W1C errWRITE 16'h0008 gives regERR=16'h0002 with FIRST still 3. W1C 16'h0002 gives regERR=0 and FIRSTV=0.
- edgeSTAT[0] 1->0 sets regERR bit 6; 0->1 does not. lvlERR[2] held high with errWRITE 16'h0004 in the same cycle: bit stays 1.
- IE=1, stsDONE 0->1: intREQ=1 next cycle. intACK clears it. A second done rise with IE cleared to 0 leaves intREQ=0.
- With intREQ=1 and ERR=1, write high byte D[8]=1: cmdINIT and cmdECLR pulse. Next cycle IE=MODE=PAR=0, regERR=0, intREQ=0.
